// File: rtl/ex_stage_rv32m.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_rv32m
// Description : RV32IM execute stage with EX/MEM/WB operand forwarding, a
//               full RV32I ALU, an iterative multiply/divide unit with a
//               stall handshake, and the registered EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_rv32m #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int OP_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic            alu_src,
  input  logic [OP_W-1:0] alu_op,
  input  logic            regwrite_in,
  input  logic            memread_in,
  input  logic            memwrite_in,
  input  logic            memtoreg_in,
  input  logic [2:0]      loadtype_in,
  input  logic [2:0]      strtype_in,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [4:0]      fwd_mem_rd,
  input  logic            fwd_mem_we,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic [4:0]      fwd_wb_rd,
  input  logic            fwd_wb_we,
  output logic            stall_out,
  output logic            valid_out,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd_out,
  output logic            regwrite_out,
  output logic            memread_out,
  output logic            memwrite_out,
  output logic            memtoreg_out,
  output logic [2:0]      loadtype_out,
  output logic [2:0]      strtype_out
);

  localparam int c_SHW     = $clog2(XLEN);
  // Multiplier bits consumed per busy cycle so MUL_CYCLES iterations cover XLEN
  localparam int c_CHUNK   = (XLEN + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam int c_CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [OP_W-1:0] c_OP_ADD    = OP_W'(0);
  localparam logic [OP_W-1:0] c_OP_SUB    = OP_W'(1);
  localparam logic [OP_W-1:0] c_OP_XOR    = OP_W'(2);
  localparam logic [OP_W-1:0] c_OP_OR     = OP_W'(3);
  localparam logic [OP_W-1:0] c_OP_AND    = OP_W'(4);
  localparam logic [OP_W-1:0] c_OP_SLL    = OP_W'(5);
  localparam logic [OP_W-1:0] c_OP_SRL    = OP_W'(6);
  localparam logic [OP_W-1:0] c_OP_SRA    = OP_W'(7);
  localparam logic [OP_W-1:0] c_OP_SLT    = OP_W'(8);
  localparam logic [OP_W-1:0] c_OP_SLTU   = OP_W'(9);
  localparam logic [OP_W-1:0] c_OP_PASSA  = OP_W'(10);
  localparam logic [OP_W-1:0] c_OP_PASSB  = OP_W'(11);
  localparam logic [OP_W-1:0] c_OP_MUL    = OP_W'(16);
  localparam logic [OP_W-1:0] c_OP_MULH   = OP_W'(17);
  localparam logic [OP_W-1:0] c_OP_MULHSU = OP_W'(18);
  localparam logic [OP_W-1:0] c_OP_MULHU  = OP_W'(19);
  localparam logic [OP_W-1:0] c_OP_DIV    = OP_W'(20);
  localparam logic [OP_W-1:0] c_OP_DIVU   = OP_W'(21);
  localparam logic [OP_W-1:0] c_OP_REM    = OP_W'(22);
  localparam logic [OP_W-1:0] c_OP_REMU   = OP_W'(23);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;

  logic [XLEN-1:0]      w_rs1_fwd;
  logic [XLEN-1:0]      w_rs2_fwd;
  logic [XLEN-1:0]      w_op2;
  logic [XLEN-1:0]      w_alu_res;
  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_issue;
  logic                 w_a_sgn;
  logic                 w_b_sgn;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [XLEN-1:0]      w_a_mag;
  logic [XLEN-1:0]      w_b_mag;

  // Captured M-unit operands and iteration state
  logic [OP_W-1:0]      r_mop;
  logic                 r_a_neg;
  logic                 r_b_neg;
  logic                 r_div0;
  logic [2*XLEN-1:0]    r_mcand;
  logic [XLEN-1:0]      r_mplier;
  logic [2*XLEN-1:0]    r_acc;
  logic [XLEN-1:0]      r_quo;
  logic [XLEN-1:0]      r_rem;
  logic [XLEN-1:0]      r_dvs;

  // Control and passthrough fields held for the retiring M-op
  logic [XLEN-1:0]      r_cap_pc;
  logic [XLEN-1:0]      r_cap_sd;
  logic [4:0]           r_cap_rd;
  logic                 r_cap_rw;
  logic                 r_cap_mr;
  logic                 r_cap_mw;
  logic                 r_cap_mtr;
  logic [2:0]           r_cap_lt;
  logic [2:0]           r_cap_st;

  logic [2*XLEN-1:0]    w_acc_nxt;
  logic [XLEN:0]        w_trial;
  logic [XLEN-1:0]      w_quo_nxt;
  logic [XLEN-1:0]      w_rem_nxt;
  logic [2*XLEN-1:0]    w_prod;
  logic [XLEN-1:0]      w_quo_fin;
  logic [XLEN-1:0]      w_rem_fin;
  logic [XLEN-1:0]      w_m_res;

  // Operand forwarding: EX/MEM beats MEM/WB, x0 always reads the register file
  always_comb begin
    w_rs1_fwd = rs1_data;
    if (fwd_mem_we && (fwd_mem_rd != 5'd0) && (fwd_mem_rd == rs1_addr))
      w_rs1_fwd = fwd_mem_data;
    else if (fwd_wb_we && (fwd_wb_rd != 5'd0) && (fwd_wb_rd == rs1_addr))
      w_rs1_fwd = fwd_wb_data;
    w_rs2_fwd = rs2_data;
    if (fwd_mem_we && (fwd_mem_rd != 5'd0) && (fwd_mem_rd == rs2_addr))
      w_rs2_fwd = fwd_mem_data;
    else if (fwd_wb_we && (fwd_wb_rd != 5'd0) && (fwd_wb_rd == rs2_addr))
      w_rs2_fwd = fwd_wb_data;
  end

  assign w_op2 = alu_src ? imm : w_rs2_fwd;

  // Single-cycle RV32I ALU; M-op and unused codes produce zero here
  always_comb begin
    w_alu_res = '0;
    case (alu_op)
      c_OP_ADD:   w_alu_res = w_rs1_fwd + w_op2;
      c_OP_SUB:   w_alu_res = w_rs1_fwd - w_op2;
      c_OP_XOR:   w_alu_res = w_rs1_fwd ^ w_op2;
      c_OP_OR:    w_alu_res = w_rs1_fwd | w_op2;
      c_OP_AND:   w_alu_res = w_rs1_fwd & w_op2;
      c_OP_SLL:   w_alu_res = w_rs1_fwd << w_op2[c_SHW-1:0];
      c_OP_SRL:   w_alu_res = w_rs1_fwd >> w_op2[c_SHW-1:0];
      c_OP_SRA:   w_alu_res = $unsigned($signed(w_rs1_fwd) >>> w_op2[c_SHW-1:0]);
      c_OP_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_rs1_fwd) < $signed(w_op2))};
      c_OP_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, (w_rs1_fwd < w_op2)};
      c_OP_PASSA: w_alu_res = w_rs1_fwd;
      c_OP_PASSB: w_alu_res = w_op2;
      default:    w_alu_res = '0;
    endcase
  end

  assign w_is_mul = (alu_op >= c_OP_MUL) && (alu_op <= c_OP_MULHU);
  assign w_is_div = (alu_op >= c_OP_DIV) && (alu_op <= c_OP_REMU);
  assign w_issue  = valid_in && !flush && (r_state == ST_IDLE) && (w_is_mul || w_is_div);

  // The M-unit works on magnitudes; signs are reapplied when the result retires
  assign w_a_sgn = (alu_op == c_OP_MULH) || (alu_op == c_OP_MULHSU) ||
                   (alu_op == c_OP_DIV)  || (alu_op == c_OP_REM);
  assign w_b_sgn = (alu_op == c_OP_MULH) || (alu_op == c_OP_DIV) || (alu_op == c_OP_REM);
  assign w_a_neg = w_a_sgn && w_rs1_fwd[XLEN-1];
  assign w_b_neg = w_b_sgn && w_op2[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_rs1_fwd : w_rs1_fwd;
  assign w_b_mag = w_b_neg ? -w_op2 : w_op2;

  // Stall covers the issue cycle and every busy cycle; a flush releases it at once
  assign stall_out = !rst && !flush && (w_issue || (r_state == ST_BUSY));

  // One shift-add step over c_CHUNK multiplier bits, one restoring-divide step
  always_comb begin
    w_acc_nxt = r_acc;
    for (int i = 0; i < c_CHUNK; i++) begin
      if (r_mplier[i])
        w_acc_nxt = w_acc_nxt + (r_mcand << i);
    end
    w_trial = {r_rem, r_quo[XLEN-1]} - {1'b0, r_dvs};
    if (!w_trial[XLEN]) begin
      w_rem_nxt = w_trial[XLEN-1:0];
      w_quo_nxt = {r_quo[XLEN-2:0], 1'b1};
    end else begin
      w_rem_nxt = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
      w_quo_nxt = {r_quo[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and divide-by-zero override of the retiring M result
  always_comb begin
    w_prod    = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
    w_quo_fin = r_div0 ? '1 : ((r_a_neg ^ r_b_neg) ? -r_quo : r_quo);
    w_rem_fin = r_a_neg ? -r_rem : r_rem;
    w_m_res   = '0;
    case (r_mop)
      c_OP_MUL:                          w_m_res = w_prod[XLEN-1:0];
      c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_m_res = w_prod[2*XLEN-1:XLEN];
      c_OP_DIV, c_OP_DIVU:               w_m_res = w_quo_fin;
      c_OP_REM, c_OP_REMU:               w_m_res = w_rem_fin;
      default:                           w_m_res = '0;
    endcase
  end

  // M-unit sequencer: IDLE -> BUSY (counter runs down) -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state <= ST_BUSY;
            r_cnt   <= w_is_mul ? c_CNT_W'(MUL_CYCLES) : c_CNT_W'(XLEN);
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - c_CNT_W'(1);
          if (r_cnt == c_CNT_W'(1))
            r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand capture at issue, then one iteration per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mop     <= '0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_div0    <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_cap_pc  <= '0;
      r_cap_sd  <= '0;
      r_cap_rd  <= '0;
      r_cap_rw  <= 1'b0;
      r_cap_mr  <= 1'b0;
      r_cap_mw  <= 1'b0;
      r_cap_mtr <= 1'b0;
      r_cap_lt  <= '0;
      r_cap_st  <= '0;
    end else if (w_issue) begin
      r_mop     <= alu_op;
      r_a_neg   <= w_a_neg;
      r_b_neg   <= w_b_neg;
      r_div0    <= (w_op2 == '0);
      r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
      r_mplier  <= w_b_mag;
      r_acc     <= '0;
      r_quo     <= w_a_mag;
      r_rem     <= '0;
      r_dvs     <= w_b_mag;
      r_cap_pc  <= pc_in;
      r_cap_sd  <= w_rs2_fwd;
      r_cap_rd  <= rd_addr;
      r_cap_rw  <= regwrite_in;
      r_cap_mr  <= memread_in;
      r_cap_mw  <= memwrite_in;
      r_cap_mtr <= memtoreg_in;
      r_cap_lt  <= loadtype_in;
      r_cap_st  <= strtype_in;
    end else if (r_state == ST_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << c_CHUNK;
      r_mplier <= r_mplier >> c_CHUNK;
      r_quo    <= w_quo_nxt;
      r_rem    <= w_rem_nxt;
    end
  end

  // EX/MEM register: bubble by default, ALU result from IDLE, M result from DONE
  always_ff @(posedge clk) begin
    valid_out      <= 1'b0;
    result_out     <= '0;
    store_data_out <= '0;
    pc_out         <= '0;
    rd_out         <= '0;
    regwrite_out   <= 1'b0;
    memread_out    <= 1'b0;
    memwrite_out   <= 1'b0;
    memtoreg_out   <= 1'b0;
    loadtype_out   <= '0;
    strtype_out    <= '0;
    if (!rst && !flush) begin
      if (r_state == ST_DONE) begin
        valid_out      <= 1'b1;
        result_out     <= w_m_res;
        store_data_out <= r_cap_sd;
        pc_out         <= r_cap_pc;
        rd_out         <= r_cap_rd;
        regwrite_out   <= r_cap_rw;
        memread_out    <= r_cap_mr;
        memwrite_out   <= r_cap_mw;
        memtoreg_out   <= r_cap_mtr;
        loadtype_out   <= r_cap_lt;
        strtype_out    <= r_cap_st;
      end else if ((r_state == ST_IDLE) && valid_in && !(w_is_mul || w_is_div)) begin
        valid_out      <= 1'b1;
        result_out     <= w_alu_res;
        store_data_out <= w_rs2_fwd;
        pc_out         <= pc_in;
        rd_out         <= rd_addr;
        regwrite_out   <= regwrite_in;
        memread_out    <= memread_in;
        memwrite_out   <= memwrite_in;
        memtoreg_out   <= memtoreg_in;
        loadtype_out   <= loadtype_in;
        strtype_out    <= strtype_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_rv32m.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage_rv32m
// Description : Self-checking bench for ex_stage_rv32m: directed corner cases
//               with literal results, then randomized traffic against a
//               cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage_rv32m;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 2;
  localparam int OP_W       = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_in, flush, alu_src;
  logic [31:0]     pc_in, rs1_data, rs2_data, imm, fwd_mem_data, fwd_wb_data;
  logic [4:0]      rs1_addr, rs2_addr, rd_addr, fwd_mem_rd, fwd_wb_rd;
  logic [4:0]      alu_op;
  logic            regwrite_in, memread_in, memwrite_in, memtoreg_in;
  logic [2:0]      loadtype_in, strtype_in;
  logic            fwd_mem_we, fwd_wb_we;
  logic            stall_out, valid_out;
  logic [31:0]     result_out, store_data_out, pc_out;
  logic [4:0]      rd_out;
  logic            regwrite_out, memread_out, memwrite_out, memtoreg_out;
  logic [2:0]      loadtype_out, strtype_out;

  always #5 clk = ~clk;

  ex_stage_rv32m #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .pc_in(pc_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_src(alu_src), .alu_op(alu_op),
    .regwrite_in(regwrite_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .memtoreg_in(memtoreg_in), .loadtype_in(loadtype_in), .strtype_in(strtype_in),
    .fwd_mem_data(fwd_mem_data), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_we(fwd_mem_we),
    .fwd_wb_data(fwd_wb_data), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_we(fwd_wb_we),
    .stall_out(stall_out), .valid_out(valid_out), .result_out(result_out),
    .store_data_out(store_data_out), .pc_out(pc_out), .rd_out(rd_out),
    .regwrite_out(regwrite_out), .memread_out(memread_out), .memwrite_out(memwrite_out),
    .memtoreg_out(memtoreg_out), .loadtype_out(loadtype_out), .strtype_out(strtype_out)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw, mr, mw, mtr;
    logic [2:0]  lt, st;
  } exreg_t;

  int     total = 0;
  int     bad   = 0;
  exreg_t m_res;
  bit     m_pend = 1'b0;
  int     m_wait = 0;
  logic   obs_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from the ISA definitions
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    logic               ovf;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a ^ b;
      5'd3:  return a | b;
      5'd4:  return a & b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return $unsigned($signed(a) >>> b[4:0]);
      5'd8:  return {31'd0, $signed(a) < $signed(b)};
      5'd9:  return {31'd0, a < b};
      5'd10: return a;
      5'd11: return b;
      5'd16: begin p = ua * ub; return p[31:0]; end
      5'd17: begin p = sa * sb; return p[63:32]; end
      5'd18: begin p = sa * $signed(ub); return p[63:32]; end
      5'd19: begin p = ua * ub; return p[63:32]; end
      5'd20: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      5'd23: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs != 5'd0 && fwd_mem_we && fwd_mem_rd == rs) return fwd_mem_data;
    if (rs != 5'd0 && fwd_wb_we && fwd_wb_rd == rs) return fwd_wb_data;
    return rf;
  endfunction

  // One pipeline cycle: predict stall and next EX/MEM content, then compare both
  task automatic step();
    logic [31:0] a, b2, o2;
    exreg_t      cur, nxt;
    logic        es;
    #1;
    a   = fwd(rs1_addr, rs1_data);
    b2  = fwd(rs2_addr, rs2_data);
    o2  = alu_src ? imm : b2;
    cur = '{v: 1'b1, res: ref_alu(alu_op, a, o2), sd: b2, pc: pc_in, rd: rd_addr,
            rw: regwrite_in, mr: memread_in, mw: memwrite_in, mtr: memtoreg_in,
            lt: loadtype_in, st: strtype_in};
    nxt = '0;
    es  = 1'b0;
    if (flush) begin
      m_pend = 1'b0;
      m_wait = 0;
    end else if (m_pend && m_wait > 0) begin
      es = 1'b1;
      m_wait--;
    end else if (m_pend) begin
      nxt    = m_res;
      m_pend = 1'b0;
    end else if (valid_in && alu_op >= 5'd16 && alu_op <= 5'd23) begin
      es     = 1'b1;
      m_pend = 1'b1;
      m_wait = (alu_op <= 5'd19) ? MUL_CYCLES : XLEN;
      m_res  = cur;
    end else if (valid_in) begin
      nxt = cur;
    end
    obs_stall = stall_out;
    chk("stall", {31'd0, stall_out}, {31'd0, es});
    @(posedge clk);
    #1;
    chk("valid", {31'd0, valid_out}, {31'd0, nxt.v});
    if (nxt.v) begin
      chk("result", result_out, nxt.res);
      chk("store_data", store_data_out, nxt.sd);
      chk("pc", pc_out, nxt.pc);
      chk("rd", {27'd0, rd_out}, {27'd0, nxt.rd});
      chk("ctrl", {22'd0, regwrite_out, memread_out, memwrite_out, memtoreg_out,
                   loadtype_out, strtype_out},
                  {22'd0, nxt.rw, nxt.mr, nxt.mw, nxt.mtr, nxt.lt, nxt.st});
    end else begin
      chk("bubble_en", {29'd0, regwrite_out, memread_out, memwrite_out}, 32'd0);
    end
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_in = 1'b1;  flush = 1'b0;  alu_op = op;
    rs1_addr = 5'd1;  rs2_addr = 5'd2;  rd_addr = 5'd3;
    rs1_data = a;  rs2_data = b;  imm = 32'd0;  alu_src = 1'b0;
    pc_in = $urandom;
    regwrite_in = 1'b1;  memread_in = 1'b0;  memwrite_in = 1'b0;  memtoreg_in = 1'b0;
    loadtype_in = 3'd2;  strtype_in = 3'd0;
    fwd_mem_we = 1'b0;  fwd_mem_rd = 5'd0;  fwd_mem_data = 32'd0;
    fwd_wb_we  = 1'b0;  fwd_wb_rd  = 5'd0;  fwd_wb_data  = 32'd0;
  endtask

  // Hold the instruction until it retires, then check the literal result and stall length
  task automatic complete(input string nm, input logic [31:0] lit, input int stalls);
    int ns  = 0;
    bit got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      step();
      if (obs_stall) ns++;
      if (valid_out) got = 1'b1;
    end
    valid_in = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s: no valid_out within 100 cycles", nm);
    end else begin
      chk(nm, result_out, lit);
      chk({nm, "_stalls"}, 32'(ns), 32'(stalls));
    end
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_op(5'd0, 32'd0, 32'd0);
    valid_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_result", result_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_ctrl", {19'd0, rd_out, regwrite_out, memread_out, memwrite_out, memtoreg_out,
                     loadtype_out, strtype_out}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);

    // Forwarding priority: EX/MEM over MEM/WB, and rd=0 never forwards
    set_op(5'd0, 32'd10, 32'd0);
    rs1_addr = 5'd5;  alu_src = 1'b1;  imm = 32'd7;
    fwd_mem_we = 1'b1;  fwd_mem_rd = 5'd5;  fwd_mem_data = 32'd100;
    fwd_wb_we  = 1'b1;  fwd_wb_rd  = 5'd5;  fwd_wb_data  = 32'd50;
    complete("fwd_mem", 32'd107, 0);
    set_op(5'd0, 32'd10, 32'd0);
    rs1_addr = 5'd5;  alu_src = 1'b1;  imm = 32'd7;
    fwd_mem_we = 1'b1;  fwd_mem_rd = 5'd0;  fwd_mem_data = 32'd100;
    fwd_wb_we  = 1'b1;  fwd_wb_rd  = 5'd0;  fwd_wb_data  = 32'd50;
    complete("fwd_x0", 32'd17, 0);

    set_op(5'd16, 32'hFFFF_FFFF, 32'd2);  complete("mul", 32'hFFFF_FFFE, MUL_CYCLES + 1);
    set_op(5'd19, 32'hFFFF_FFFF, 32'd2);  complete("mulhu", 32'h0000_0001, MUL_CYCLES + 1);
    set_op(5'd17, 32'hFFFF_FFFF, 32'd2);  complete("mulh", 32'hFFFF_FFFF, MUL_CYCLES + 1);
    set_op(5'd20, -32'sd7, 32'd2);        complete("div", 32'hFFFF_FFFD, XLEN + 1);
    set_op(5'd22, -32'sd7, 32'd2);        complete("rem", 32'hFFFF_FFFF, XLEN + 1);
    set_op(5'd21, 32'd7, 32'd0);          complete("divu_by0", 32'hFFFF_FFFF, XLEN + 1);
    set_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF); complete("rem_ovf", 32'd0, XLEN + 1);
    set_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF); complete("div_ovf", 32'h8000_0000, XLEN + 1);
    set_op(5'd7, 32'h8000_0000, 32'd4);   complete("sra", 32'hF800_0000, 0);
    set_op(5'd9, 32'd1, 32'hFFFF_FFFF);   complete("sltu", 32'd1, 0);
    set_op(5'd8, 32'd1, 32'hFFFF_FFFF);   complete("slt", 32'd0, 0);
    set_op(5'd30, 32'd5, 32'd6);          complete("undef_op", 32'd0, 0);

    // Flush a divide five cycles after issue, then a plain add must complete
    set_op(5'd20, 32'd100, 32'd7);
    repeat (5) step();
    flush = 1'b1;
    step();
    chk("flush_stall", {31'd0, obs_stall}, 32'd0);
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    flush = 1'b0;
    valid_in = 1'b0;
    step();
    set_op(5'd0, 32'd3, 32'd4);           complete("post_flush_add", 32'd7, 0);

    // Randomized traffic, small register range so forwarding hits often
    for (int c = 0; c < 3000; c++) begin
      valid_in     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 49) == 0);
      alu_op       = 5'($urandom_range(0, 31));
      rs1_addr     = 5'($urandom_range(0, 3));
      rs2_addr     = 5'($urandom_range(0, 3));
      rd_addr      = 5'($urandom_range(0, 31));
      rs1_data     = rv();
      rs2_data     = rv();
      imm          = rv();
      alu_src      = ($urandom_range(0, 3) == 0);
      pc_in        = $urandom;
      regwrite_in  = 1'($urandom_range(0, 1));
      memread_in   = 1'($urandom_range(0, 1));
      memwrite_in  = 1'($urandom_range(0, 1));
      memtoreg_in  = 1'($urandom_range(0, 1));
      loadtype_in  = 3'($urandom_range(0, 7));
      strtype_in   = 3'($urandom_range(0, 7));
      fwd_mem_we   = 1'($urandom_range(0, 1));
      fwd_mem_rd   = 5'($urandom_range(0, 3));
      fwd_mem_data = rv();
      fwd_wb_we    = 1'($urandom_range(0, 1));
      fwd_wb_rd    = 5'($urandom_range(0, 3));
      fwd_wb_data  = rv();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
